// File: rtl/phi_bus_ctrl.sv
// Two-phase CPU clock generator and bus controller that registers each access into one-clk strobes.
// Define PHI_STRETCH_EN to let mem_ack stretch phi2 through a WAIT state.
module phi_bus_ctrl #(
    parameter int unsigned HALF_DIV = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_ab,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_dbo,
    output logic        phi,
    output logic [7:0]  cpu_dbi,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);

    localparam logic [7:0] CntLast = 8'(HALF_DIV - 1);

`ifdef PHI_STRETCH_EN
    typedef enum logic [1:0] {StPh1, StPh2, StWait} state_t;
`else
    typedef enum logic [1:0] {StPh1, StPh2} state_t;
`endif

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic        r_phi, w_phi_nxt;
    logic        r_done, w_done_nxt;
    logic        r_rd, w_rd_nxt;
    logic        r_re, w_re_nxt;
    logic        r_we, w_we_nxt;
    logic [15:0] r_addr, w_addr_nxt;
    logic [7:0]  r_wdata, w_wdata_nxt;
    logic [7:0]  r_dbi, w_dbi_nxt;

`ifdef PHI_STRETCH_EN
    logic w_ack_ok;
    // Only the first ack after the strobe counts; PH1 acks and repeats are dropped.
    assign w_ack_ok = mem_ack && !r_done && (r_state != StPh1);
`else
    logic w_unused_ack;
    assign w_unused_ack = mem_ack;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 8'd1;
        w_phi_nxt   = r_phi;
        w_done_nxt  = r_done;
        w_rd_nxt    = r_rd;
        w_re_nxt    = 1'b0;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_dbi_nxt   = r_dbi;

`ifdef PHI_STRETCH_EN
        if (w_ack_ok) begin
            w_done_nxt = 1'b1;
            if (r_rd) w_dbi_nxt = mem_rdata;
        end
`endif

        unique case (r_state)
            StPh1: begin
                if (r_cnt == CntLast) begin
                    w_state_nxt = StPh2;
                    w_cnt_nxt   = 8'd0;
                    w_phi_nxt   = 1'b1;
                    w_addr_nxt  = cpu_ab;
                    w_wdata_nxt = cpu_dbo;
                    w_rd_nxt    = cpu_rw;
                    w_re_nxt    = cpu_rw;
                    w_we_nxt    = ~cpu_rw;
                end
            end
            StPh2: begin
                if (r_cnt == CntLast) begin
`ifdef PHI_STRETCH_EN
                    if (r_done || w_ack_ok) begin
                        w_state_nxt = StPh1;
                        w_cnt_nxt   = 8'd0;
                        w_phi_nxt   = 1'b0;
                        w_done_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = StWait;
                        w_cnt_nxt   = r_cnt;
                    end
`else
                    if (r_rd) w_dbi_nxt = mem_rdata;
                    w_state_nxt = StPh1;
                    w_cnt_nxt   = 8'd0;
                    w_phi_nxt   = 1'b0;
`endif
                end
            end
`ifdef PHI_STRETCH_EN
            StWait: begin
                // Counter parks at its last value so it cannot wrap while stretched.
                w_cnt_nxt = r_cnt;
                if (w_ack_ok) begin
                    w_state_nxt = StPh1;
                    w_cnt_nxt   = 8'd0;
                    w_phi_nxt   = 1'b0;
                    w_done_nxt  = 1'b0;
                end
            end
`endif
            default: begin
                w_state_nxt = StPh1;
                w_cnt_nxt   = 8'd0;
                w_phi_nxt   = 1'b0;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StPh1;
            r_cnt   <= 8'd0;
            r_phi   <= 1'b0;
            r_done  <= 1'b0;
            r_rd    <= 1'b0;
            r_re    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 16'h0000;
            r_wdata <= 8'h00;
            r_dbi   <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_phi   <= w_phi_nxt;
            r_done  <= w_done_nxt;
            r_rd    <= w_rd_nxt;
            r_re    <= w_re_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_dbi   <= w_dbi_nxt;
        end
    end

    assign phi       = r_phi;
    assign cpu_dbi   = r_dbi;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_re    = r_re;
    assign mem_we    = r_we;

endmodule

// File: tb/tb_phi_bus_ctrl.sv
// Directed bench for phi_bus_ctrl at HALF_DIV=4; expectations follow PHI_STRETCH_EN when defined.
module tb_phi_bus_ctrl;

`ifdef PHI_STRETCH_EN
    localparam bit Stretch = 1'b1;
`else
    localparam bit Stretch = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cpu_ab;
    logic        cpu_rw;
    logic [7:0]  cpu_dbo;
    logic        phi;
    logic [7:0]  cpu_dbi;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    int   n_pass = 0;
    int   n_total = 0;
    int   rise_cnt = 0;
    int   strb_cnt = 0;
    logic prev_phi = 1'b0;

    // Responder: acks r_ack_dly clks after the strobe clk (0 = in the strobe clk).
    bit   r_resp_en = 1'b0;
    int   r_ack_dly = 0;
    int   r_cd = -1;
    logic r_resp_ack = 1'b0;
    logic r_man_ack = 1'b0;

    assign mem_ack = r_resp_ack | r_man_ack;

    phi_bus_ctrl #(.HALF_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_ab    (cpu_ab),
        .cpu_rw    (cpu_rw),
        .cpu_dbo   (cpu_dbo),
        .phi       (phi),
        .cpu_dbi   (cpu_dbi),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (r_resp_en && (mem_re || mem_we)) r_cd = r_ack_dly;
        else if (r_cd >= 0) r_cd = r_cd - 1;
        r_resp_ack = (r_cd == 0);
        if (phi && !prev_phi) rise_cnt = rise_cnt + 1;
        if (mem_re || mem_we) strb_cnt = strb_cnt + 1;
        prev_phi = phi;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Counts consecutive sampled clks (from the current one) with phi at lvl.
    task automatic measure(input logic lvl, output int n);
        n = 0;
        while (phi == lvl && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        cpu_ab    = 16'h0000;
        cpu_rw    = 1'b1;
        cpu_dbo   = 8'h00;
        mem_rdata = 8'h00;

        repeat (3) step();
        chk("rst_phi",   32'(phi),       32'h0);
        chk("rst_re",    32'(mem_re),    32'h0);
        chk("rst_we",    32'(mem_we),    32'h0);
        chk("rst_addr",  32'(mem_addr),  32'h0);
        chk("rst_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_dbi",   32'(cpu_dbi),   32'h0);

        // Idle running: phi toggles every 4 clks, strobe in first clk of each phi2.
        r_resp_en = 1'b1;
        r_ack_dly = 0;
        rst_n     = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("idle_phi", 32'(phi), 32'((k / 4) % 2));
            chk("idle_re",  32'(mem_re), 32'(k % 8 == 4));
        end

        // Read FFFC, ack in strobe clk.
        cpu_ab    = 16'hFFFC;
        cpu_rw    = 1'b1;
        mem_rdata = 8'hA5;
        measure(1'b0, n);
        chk("rd_ph1_len", n, 4);
        chk("rd_addr", 32'(mem_addr), 32'hFFFC);
        chk("rd_re",   32'(mem_re),   32'h1);
        chk("rd_we",   32'(mem_we),   32'h0);
        step();
        cpu_ab = 16'h0000;
        chk("rd_re_off",    32'(mem_re),  32'h0);
        chk("rd_dbi_early", 32'(cpu_dbi), Stretch ? 32'hA5 : 32'h0);
        measure(1'b1, n);
        chk("rd_ph2_len",   n + 1, 4);
        chk("rd_dbi",       32'(cpu_dbi),  32'hA5);
        chk("rd_addr_hold", 32'(mem_addr), 32'hFFFC);

        // Write D012/8D, ack one clk after strobe.
        cpu_ab    = 16'hD012;
        cpu_dbo   = 8'h8D;
        cpu_rw    = 1'b0;
        mem_rdata = 8'h5A;
        r_ack_dly = 1;
        measure(1'b0, n);
        chk("wr_ph1_len", n, 4);
        chk("wr_we",    32'(mem_we),    32'h1);
        chk("wr_re",    32'(mem_re),    32'h0);
        chk("wr_wdata", 32'(mem_wdata), 32'h8D);
        chk("wr_addr",  32'(mem_addr),  32'hD012);
        measure(1'b1, n);
        chk("wr_ph2_len", n, 4);
        chk("wr_dbi",     32'(cpu_dbi), 32'hA5);

        // Read with ack 10 clks after strobe.
        cpu_ab    = 16'h1234;
        cpu_rw    = 1'b1;
        mem_rdata = 8'h3C;
        r_ack_dly = 10;
        measure(1'b0, n);
        chk("dly_ph1_len", n, 4);
        chk("dly_re", 32'(mem_re), 32'h1);
        measure(1'b1, n);
        chk("dly_ph2_len", n, Stretch ? 32'd11 : 32'd4);
        chk("dly_dbi", 32'(cpu_dbi), 32'h3C);

        // Ack during PH1 (dropped), then ack in strobe clk plus a second ack.
        chk("pa_phi", 32'(phi), 32'h0);
        cpu_ab    = 16'h0042;
        mem_rdata = 8'h11;
        r_man_ack = 1'b1;
        r_ack_dly = 0;
        step();
        r_man_ack = 1'b0;
        mem_rdata = 8'h77;
        chk("pa_ph1_ign", 32'(cpu_dbi), 32'h3C);
        measure(1'b0, n);
        chk("pa_ph1_len", n + 1, 4);
        chk("pa_addr", 32'(mem_addr), 32'h0042);
        chk("pa_re",   32'(mem_re),   32'h1);
        step();
        chk("pa_dbi_first", 32'(cpu_dbi), Stretch ? 32'h77 : 32'h3C);
        r_man_ack = 1'b1;
        mem_rdata = 8'h99;
        step();
        r_man_ack = 1'b0;
        mem_rdata = 8'h77;
        chk("pa_dbl_ign", 32'(cpu_dbi), Stretch ? 32'h77 : 32'h3C);
        step();
        chk("pa_phi_s3", 32'(phi), 32'h1);
        step();
        chk("pa_phi_s4", 32'(phi), 32'h0);
        chk("pa_dbi",    32'(cpu_dbi), 32'h77);

        // No ack: stretched builds park in WAIT, then reset mid-access.
        cpu_ab    = 16'hBEEF;
        mem_rdata = 8'hEE;
        r_resp_en = 1'b0;
        measure(1'b0, n);
        chk("rw_ph1_len", n, 4);
        repeat (6) step();
        chk("rw_wait_phi", 32'(phi), Stretch ? 32'h1 : 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_phi",  32'(phi),      32'h0);
        chk("rw_re",   32'(mem_re),   32'h0);
        chk("rw_we",   32'(mem_we),   32'h0);
        chk("rw_addr", 32'(mem_addr), 32'h0);
        chk("rw_dbi",  32'(cpu_dbi),  32'h0);
        step();
        step();
        rst_n     = 1'b1;
        r_man_ack = 1'b1;
        chk("rel_phi", 32'(phi), 32'h0);
        step();
        r_man_ack = 1'b0;
        chk("rel_late_ack", 32'(cpu_dbi), 32'h0);
        measure(1'b0, n);
        chk("rel_ph1_len", n + 1, 4);
        chk("rel_addr", 32'(mem_addr), 32'hBEEF);
        chk("rel_re",   32'(mem_re),   32'h1);

        #1;
        chk("rise_total",  rise_cnt, 8);
        chk("strb_total",  strb_cnt, 8);
        chk("strb_vs_phi", strb_cnt, rise_cnt);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
